// File: rtl/uart_bus_master.sv
// Byte-stream command bridge: decodes R/W frames from a UART receiver and
// replays them as single transfers on the SoC valid/ready bus, replying via a UART transmitter.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  CMD_READ       = 8'h52,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        rx_overrun,
    output logic        timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_NAK,
        RSP_READ
    } resp_t;

    state_t        r_state;
    state_t        w_next;
    resp_t         r_resp;
    logic          r_is_write;
    logic [1:0]    r_idx;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_overrun;
    logic          r_timeout;

    logic          w_op_write;
    logic          w_op_known;
    logic          w_in_frame;
    logic          w_tmo_fire;
    logic          w_field_last;
    logic          w_resp_last;
    logic [7:0]    w_tx_byte;

    assign w_op_write   = (rx_data == CMD_WRITE);
    assign w_op_known   = w_op_write || (rx_data == CMD_READ);
    assign w_in_frame   = (r_state == S_ADDR) || (r_state == S_DATA);
    // Counter holds the number of silent cycles already elapsed; firing wins over a same-cycle byte.
    assign w_tmo_fire   = w_in_frame && (r_tmo_cnt == TMO_LAST);
    assign w_field_last = (r_idx == 2'd3);
    assign w_resp_last  = (r_resp == RSP_READ) ? w_field_last : 1'b1;

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign rx_overrun  = r_overrun;
    assign timeout_err = r_timeout;

    always_comb begin
        w_tx_byte = NAK_BYTE;
        case (r_resp)
            RSP_ACK:  w_tx_byte = ACK_BYTE;
            RSP_NAK:  w_tx_byte = NAK_BYTE;
            RSP_READ: begin
                case (r_idx)
                    2'd0:    w_tx_byte = r_rdata[7:0];
                    2'd1:    w_tx_byte = r_rdata[15:8];
                    2'd2:    w_tx_byte = r_rdata[23:16];
                    default: w_tx_byte = r_rdata[31:24];
                endcase
            end
            default:  w_tx_byte = NAK_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_next = w_op_known ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (w_tmo_fire) begin
                    w_next = S_IDLE;
                end else if (rx_valid && w_field_last) begin
                    w_next = r_is_write ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                if (w_tmo_fire) begin
                    w_next = S_IDLE;
                end else if (rx_valid && w_field_last) begin
                    w_next = S_BUS;
                end
            end
            S_BUS: begin
                mem_valid = 1'b1;
                mem_wstrb = r_is_write ? 4'hF : 4'h0;
                if (mem_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = w_tx_byte;
                if (tx_ready && w_resp_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp     <= RSP_NAK;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_tmo_cnt  <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overrun <= rx_valid && ((r_state == S_BUS) || (r_state == S_RESP));
            r_timeout <= w_tmo_fire;

            if (w_in_frame && !rx_valid && !w_tmo_fire) begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end else begin
                r_tmo_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (rx_valid) begin
                        r_is_write <= w_op_write;
                        if (!w_op_known) begin
                            r_resp <= RSP_NAK;
                        end else if (w_op_write) begin
                            r_resp <= RSP_ACK;
                        end else begin
                            r_resp <= RSP_READ;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_tmo_fire) begin
                        r_idx <= '0;
                    end else if (rx_valid) begin
                        r_addr <= {rx_data, r_addr[31:8]};
                        r_idx  <= r_idx + 2'd1;
                    end
                end
                S_DATA: begin
                    if (w_tmo_fire) begin
                        r_idx <= '0;
                    end else if (rx_valid) begin
                        r_wdata <= {rx_data, r_wdata[31:8]};
                        r_idx   <= r_idx + 2'd1;
                    end
                end
                S_BUS: begin
                    r_idx <= '0;
                    if (mem_ready) begin
                        r_rdata <= mem_rdata;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        r_idx <= w_resp_last ? 2'd0 : r_idx + 2'd1;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus queues expected bus transfers
// and reply bytes, negedge monitor pops and compares them as the DUT presents them.
module tb_uart_bus_master;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        rx_overrun;
    logic        timeout_err;

    uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy), .rx_overrun(rx_overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          len;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          checks = 0;
    int          errors = 0;
    int          bus_wait = 0;
    logic [31:0] bus_rdata = '0;
    int          tx_stall = 0;
    int          ovr_seen = 0;
    int          tmo_seen = 0;
    int          bus_seen = 0;
    int unsigned tmo_cyc = 0;
    int unsigned last_strobe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus target: completes each request after bus_wait stall cycles.
    initial begin : bus_target
        int wc;
        wc = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (mem_valid) begin
                if (wc == bus_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = bus_rdata;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Transmitter: accepts each byte after tx_stall stall cycles.
    initial begin : tx_target
        int tc;
        tc = 0;
        forever begin
            @(posedge clk); #1;
            tx_ready = 1'b0;
            if (tx_valid) begin
                if (tc == tx_stall) begin
                    tx_ready = 1'b1;
                    tc = 0;
                end else begin
                    tc++;
                end
            end else begin
                tc = 0;
            end
        end
    end

    initial begin : monitor
        logic prev_valid;
        logic prev_ready;
        bus_t cur;
        int   vlen;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        vlen = 0;
        cur = '{addr: '0, wdata: '0, wstrb: '0, len: 0};
        forever begin
            @(negedge clk);
            if (prev_ready) begin
                chk("mem_valid_drop", 32'(mem_valid), 32'd0);
                chk("tx_valid_latency", 32'(tx_valid), 32'd1);
            end
            if (mem_valid && !prev_valid) begin
                bus_seen++;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: got addr %h wstrb %h expected no request", mem_addr, mem_wstrb);
                end else begin
                    cur = exp_bus.pop_front();
                    chk("bus_addr", mem_addr, cur.addr);
                    chk("bus_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                    if (cur.wstrb == 4'hF) chk("bus_wdata", mem_wdata, cur.wdata);
                    vlen = 1;
                end
            end else if (mem_valid) begin
                vlen++;
                chk("bus_addr_stable", mem_addr, cur.addr);
            end
            if (!mem_valid && prev_valid && cur.len != 0) chk("bus_valid_len", vlen, cur.len);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            if (rx_overrun) ovr_seen++;
            if (timeout_err) begin
                tmo_seen++;
                tmo_cyc = cyc;
            end
            prev_valid = mem_valid;
            prev_ready = mem_ready;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_valid = 1'b1;
        last_strobe = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_addr(input logic [31:0] a);
        logic [31:0] v;
        v = a;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0]);
            v = v >> 8;
        end
    endtask

    task automatic send_w(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        send_addr(a);
        send_addr(d);
    endtask

    task automatic send_r(input logic [31:0] a);
        send_byte(8'h52);
        send_addr(a);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int len);
        bus_t e;
        e.addr = a;
        e.wdata = d;
        e.wstrb = s;
        e.len = len;
        exp_bus.push_back(e);
    endtask

    task automatic push_rd(input logic [31:0] d);
        exp_tx.push_back(d[7:0]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[31:24]);
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_bus.size() == 0 && !busy) ok = 1'b1;
        end
        chk({"done_", name}, 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ovr_base;
        logic ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_pulses", {30'd0, rx_overrun, timeout_err}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // 1: write frame
        bus_wait = 2;
        tx_stall = 0;
        push_bus(32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 3);
        exp_tx.push_back(8'h06);
        send_w(32'h2000_0000, 32'hDEAD_BEEF);
        chk("w_mem_valid_latency", 32'(mem_valid), 32'd1);
        wait_done("write");

        // 2: read with bus wait and tx stalls
        bus_wait = 5;
        bus_rdata = 32'h1234_5678;
        tx_stall = 3;
        push_bus(32'h2000_0000, 32'h0, 4'h0, 6);
        push_rd(32'h1234_5678);
        send_r(32'h2000_0000);
        chk("r_mem_valid_latency", 32'(mem_valid), 32'd1);
        wait_done("read");

        // 3: unknown opcode, then read to an unaligned address
        tx_stall = 1;
        exp_tx.push_back(8'h15);
        send_byte(8'h41);
        wait_done("nak");
        bus_wait = 0;
        bus_rdata = 32'hA5C3_0F81;
        push_bus(32'h0000_1003, 32'h0, 4'h0, 1);
        push_rd(32'hA5C3_0F81);
        send_r(32'h0000_1003);
        wait_done("read_after_nak");

        // 4: inter-byte timeout inside the address field
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h02);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (tmo_seen != 0) ok = 1'b1;
        end
        chk("timeout_seen", 32'(ok), 32'd1);
        chk("timeout_cycle", tmo_cyc, last_strobe + 17);
        chk("timeout_busy", 32'(busy), 32'd0);
        bus_wait = 1;
        push_bus(32'h0000_0404, 32'h0102_0304, 4'hF, 2);
        exp_tx.push_back(8'h06);
        send_w(32'h0000_0404, 32'h0102_0304);
        wait_done("write_after_timeout");

        // 5: bytes arriving during BUS and RESP are dropped
        ovr_base = ovr_seen;
        bus_wait = 8;
        bus_rdata = 32'hCAFE_F00D;
        tx_stall = 3;
        push_bus(32'h8000_0010, 32'h0, 4'h0, 9);
        push_rd(32'hCAFE_F00D);
        send_r(32'h8000_0010);
        send_byte(8'h55);
        send_byte(8'hAA);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1'b1;
        end
        chk("resp_reached", 32'(ok), 32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_done("overrun");
        chk("overrun_count", ovr_seen - ovr_base, 32'd4);

        // 6: reset during an outstanding bus request
        bus_wait = 1000;
        push_bus(32'h3000_0000, 32'h0, 4'h0, 0);
        send_r(32'h3000_0000);
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        bus_wait = 1;
        tx_stall = 0;
        push_bus(32'h3000_0004, 32'h55AA_33CC, 4'hF, 2);
        exp_tx.push_back(8'h06);
        send_w(32'h3000_0004, 32'h55AA_33CC);
        wait_done("write_after_reset");

        chk("total_overruns", ovr_seen, 32'd4);
        chk("total_timeouts", tmo_seen, 32'd1);
        chk("total_bus_requests", bus_seen, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
